// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and limits for the multi-port data memory
package dmem_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    localparam int MAX_PORTS   = 8;
    localparam int MAX_LATENCY = 15;

    // Wide enough to count up to MAX_LATENCY-1.
    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - request arbiter for the multi-port data memory
//
// Parameters: NUM_PORTS (1..8)
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   req     in  NUM_PORTS eligible-request vector
//   gnt_en  in  grant allowed this cycle
//   gnt     out one-hot grant (all zero when nothing granted)
//   gnt_id  out encoded index of the granted port
// Macro DMEM_RR_ARB_EN selects round-robin; otherwise fixed priority (port 0 highest).
module dmem_arb #(
    parameter  int NUM_PORTS = 2,
    localparam int ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 gnt_en,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [ID_W-1:0]      gnt_id
);

    int   sel;
    logic found;

`ifdef DMEM_RR_ARB_EN
    logic [ID_W-1:0] ptr;

    // Points at the last granted port; reset value makes port 0 win first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= ID_W'(NUM_PORTS - 1);
        end else if (found) begin
            ptr <= gnt_id;
        end
    end

    // Each requester's distance from ptr+1 (with wrap); the smallest wins.
    always_comb begin
        int best;
        sel   = 0;
        found = 1'b0;
        best  = NUM_PORTS;
        if (gnt_en) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                int d;
                d = (i - int'(ptr) - 1 + 2 * NUM_PORTS) % NUM_PORTS;
                if (req[i] && d < best) begin
                    best  = d;
                    sel   = i;
                    found = 1'b1;
                end
            end
        end
    end
`else
    logic unused_arb;
    assign unused_arb = clk ^ rst;

    // Walk downward so the lowest-index requester is the final assignment.
    always_comb begin
        sel   = 0;
        found = 1'b0;
        if (gnt_en) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    sel   = i;
                    found = 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gnt[i] = found && (sel == i);
        end
        gnt_id = ID_W'(sel);
    end

endmodule

// File: rtl/mp_d_mem.sv
// rtl/mp_d_mem.sv - multi-port data memory with fixed access latency and arbitration
//
// Parameters: NUM_PORTS (1..8), DATA_W, DEPTH, LATENCY (1..15), ADDR_W (derived)
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   re       in  per-port read request, held until that port's done
//   we       in  per-port write request, held until that port's done (wins over re)
//   addr     in  flattened per-port word address, port p at [p*ADDR_W +: ADDR_W]
//   wdata    in  flattened per-port write data, port p at [p*DATA_W +: DATA_W]
//   rd_data  out read data, valid during a read's done cycle, held otherwise
//   done     out one-hot one-cycle completion pulse
//   busy     out access in flight
// Macro DMEM_RR_ARB_EN (in dmem_arb) selects round-robin arbitration.
module mp_d_mem
    import dmem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 2048,
    parameter int LATENCY   = 4,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        re,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]           rd_data,
    output logic [NUM_PORTS-1:0]        done,
    output logic                        busy
);

    localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    initial begin
        assert (LATENCY >= 1 && LATENCY <= MAX_LATENCY && NUM_PORTS >= 1 && NUM_PORTS <= MAX_PORTS)
        else $fatal(1, "mp_d_mem: LATENCY or NUM_PORTS out of range");
    end

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Contents are deliberately not reset; power-up image is mem[i] = i.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DATA_W'(unsigned'(i));
        end
    end

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [ID_W-1:0]     port_cap;
    op_t                 op_cap;
    logic [ADDR_W-1:0]   addr_cap;
    logic [DATA_W-1:0]   wdata_cap;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] gnt;
    logic [ID_W-1:0]      gnt_id;
    logic                 load;
    logic                 fire;
    logic                 in_range;
    op_t                  op_sel;
    logic [ADDR_W-1:0]    addr_sel;
    logic [DATA_W-1:0]    wdata_sel;

    // A port pulsing done is masked so its still-high request is not reissued.
    assign req  = (re | we) & ~done;
    assign busy = (state == ACCESS);

    // Non-power-of-2 DEPTH leaves a hole at the top of the address space.
    assign in_range = {1'b0, addr_cap} < (ADDR_W + 1)'(DEPTH);

    dmem_arb #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt_en (state == IDLE),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        op_sel    = OP_RD;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                op_sel    = we[p] ? OP_WR : OP_RD;
                addr_sel  = addr[p*ADDR_W +: ADDR_W];
                wdata_sel = wdata[p*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (|gnt) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == CNT_W'(LATENCY - 1)) begin
                    fire      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            done      <= '0;
            rd_data   <= '0;
            port_cap  <= '0;
            op_cap    <= OP_RD;
            addr_cap  <= '0;
            wdata_cap <= '0;
        end else begin
            state <= state_nxt;
            done  <= '0;
            if (load) begin
                port_cap  <= gnt_id;
                op_cap    <= op_sel;
                addr_cap  <= addr_sel;
                wdata_cap <= wdata_sel;
                cnt       <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
            if (fire) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (port_cap == ID_W'(p)) begin
                        done[p] <= 1'b1;
                    end
                end
                if (op_cap == OP_RD) begin
                    rd_data <= in_range ? mem[addr_cap] : '0;
                end
            end
        end
    end

    // Reset aborts an in-flight write, so rst gates the array write.
    always_ff @(posedge clk) begin
        if (!rst && fire && op_cap == OP_WR && in_range) begin
            mem[addr_cap] <= wdata_cap;
        end
    end

endmodule

// File: tb/tb_mp_d_mem.sv
// tb/tb_mp_d_mem.sv - directed self-checking bench for mp_d_mem
module tb_mp_d_mem;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   re, we, re1, we1;
    logic [21:0]  addr, addr1;
    logic [127:0] wdata, wdata1;
    logic [63:0]  rd_data, rd_data1;
    logic [1:0]   done, done1;
    logic         busy, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mp_d_mem dut (
        .clk     (clk),
        .rst     (rst),
        .re      (re),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rd_data (rd_data),
        .done    (done),
        .busy    (busy)
    );

    mp_d_mem #(.LATENCY(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .re      (re1),
        .we      (we1),
        .addr    (addr1),
        .wdata   (wdata1),
        .rd_data (rd_data1),
        .done    (done1),
        .busy    (busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [1:0] alt_exp [3];
    logic [63:0] alt_rd [3];

    initial begin
        rst = 1'b1;
        re = '0; we = '0; addr = '0; wdata = '0;
        re1 = '0; we1 = '0; addr1 = '0; wdata1 = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_rd_data", rd_data, 64'h0);
        chk("reset_done_l1", 64'(done1), 64'h0);

        // Single read of 0x005 by port 0
        re = 2'b01; addr[10:0] = 11'h005;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rd_busy_c%0d", i), 64'(busy), 64'h1);
            chk($sformatf("rd_nodone_c%0d", i), 64'(done), 64'h0);
        end
        step();
        chk("rd_done", 64'(done), 64'h1);
        chk("rd_data_5", rd_data, 64'h5);
        chk("rd_busy_low", 64'(busy), 64'h0);
        re = 2'b00;
        step();
        chk("rd_done_pulse", 64'(done), 64'h0);
        chk("rd_data_hold", rd_data, 64'h5);

        // Port 1 writes 0x7FF, then port 0 reads it back
        we = 2'b10; addr[21:11] = 11'h7FF; wdata[127:64] = 64'hDEADBEEF_CAFEF00D;
        repeat (5) step();
        chk("wr_done", 64'(done), 64'h2);
        chk("wr_rd_data_hold", rd_data, 64'h5);
        we = 2'b00;
        wdata[127:64] = 64'h0;
        re = 2'b01; addr[10:0] = 11'h7FF;
        repeat (5) step();
        chk("raw_done", 64'(done), 64'h1);
        chk("raw_data", rd_data, 64'hDEADBEEF_CAFEF00D);
        re = 2'b00;
        step();

        // Both ports request continuously; done-masking makes them alternate
        alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01;
        alt_rd[0] = 64'h1;  alt_rd[1] = 64'h2;  alt_rd[2] = 64'h1;
        re = 2'b11; addr[10:0] = 11'h001; addr[21:11] = 11'h002;
        for (int k = 0; k < 3; k++) begin
            repeat (5) step();
            chk($sformatf("alt_done_%0d", k), 64'(done), 64'(alt_exp[k]));
            chk($sformatf("alt_data_%0d", k), rd_data, alt_rd[k]);
            if (k == 2) re = 2'b00;
        end
        step();
        chk("alt_idle", 64'(busy), 64'h0);

        // LATENCY=1: re+we on one port is a write
        re1 = 2'b01; we1 = 2'b01; addr1[10:0] = 11'h010; wdata1[63:0] = 64'h1234;
        step();
        chk("l1_busy", 64'(busy1), 64'h1);
        step();
        chk("l1_wr_done", 64'(done1), 64'h1);
        chk("l1_wr_busy", 64'(busy1), 64'h0);
        re1 = 2'b00; we1 = 2'b00;
        step();
        re1 = 2'b01;
        step();
        step();
        chk("l1_rd_done", 64'(done1), 64'h1);
        chk("l1_rd_data", rd_data1, 64'h1234);
        re1 = 2'b00;
        step();

        // Reset while the write to 0x020 is at cnt=2
        we = 2'b01; addr[10:0] = 11'h020; wdata[63:0] = 64'hFFFF;
        step();
        step();
        step();
        rst = 1'b1; we = 2'b00;
        step();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("abort_nodone_%0d", i), 64'(done), 64'h0);
        end
        re = 2'b01;
        repeat (5) step();
        chk("abort_rd_done", 64'(done), 64'h1);
        chk("abort_rd_data", rd_data, 64'h20);
        re = 2'b00;
        step();

        // Port 0 holds re through done: idle one cycle, then re-granted
        re = 2'b01; addr[10:0] = 11'h003;
        repeat (5) step();
        chk("held_done1", 64'(done), 64'h1);
        chk("held_data1", rd_data, 64'h3);
        step();
        chk("held_gap_busy", 64'(busy), 64'h0);
        chk("held_gap_done", 64'(done), 64'h0);
        step();
        chk("held_regrant", 64'(busy), 64'h1);
        repeat (4) step();
        chk("held_done2", 64'(done), 64'h1);
        re = 2'b00;
        step();
        chk("held_end", 64'(busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
